// File: rtl/fp16_normalize_stage.sv
// Post-add normalization for the half-precision adder: two-stage valid/ready pipeline.
// S1 captures the raw sum and its leading-one index; S2 shifts, adjusts the exponent and flags.
module fp16_normalize_stage #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_carry,
    input  logic              in_hidden,
    input  logic [FRAC_W-1:0] in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_zero
);

    localparam int L_W   = $clog2(FRAC_W);
    localparam int SH_W  = $clog2(FRAC_W + 1);
    localparam int CMP_W = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic              s1_adv;
    logic              s2_adv;
    logic              s1_load;
    logic              s2_load;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic              s1_carry_q, s1_carry_d;
    logic              s1_hidden_q, s1_hidden_d;
    logic [FRAC_W-1:0] s1_frac_q, s1_frac_d;
    logic [L_W-1:0]    s1_lead_q, s1_lead_d;
    logic              s1_nz_q, s1_nz_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
    logic [FRAC_W-1:0] s2_frac_q, s2_frac_d;
    logic              s2_ovf_q, s2_ovf_d;
    logic              s2_unf_q, s2_unf_d;
    logic              s2_zero_q, s2_zero_d;

    logic [L_W-1:0]    lead;
    logic [SH_W-1:0]   sh;
    logic [FRAC_W-1:0] frac_shl;
    logic [EXP_W-1:0]  exp_inc;
    logic [CMP_W-1:0]  exp_wide;
    logic [CMP_W-1:0]  sh_wide;

    logic              res_sign;
    logic [EXP_W-1:0]  res_exp;
    logic [FRAC_W-1:0] res_frac;
    logic              res_ovf;
    logic              res_unf;
    logic              res_zero;

    // in_ready depends combinationally on out_ready so a full pipe still streams 1 beat/cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = s1_valid_q && s2_adv;

    always_comb begin
        lead = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (in_frac[i]) begin
                lead = L_W'(i);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_carry_d  = s1_carry_q;
        s1_hidden_d = s1_hidden_q;
        s1_frac_d   = s1_frac_q;
        s1_lead_d   = s1_lead_q;
        s1_nz_d     = s1_nz_q;
        if (s1_load) begin
            s1_sign_d   = in_sign;
            s1_exp_d    = in_exp;
            s1_carry_d  = in_carry;
            s1_hidden_d = in_hidden;
            s1_frac_d   = in_frac;
            s1_lead_d   = lead;
            s1_nz_d     = |in_frac;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_carry_q  <= 1'b0;
            s1_hidden_q <= 1'b0;
            s1_frac_q   <= '0;
            s1_lead_q   <= '0;
            s1_nz_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_carry_q  <= s1_carry_d;
            s1_hidden_q <= s1_hidden_d;
            s1_frac_q   <= s1_frac_d;
            s1_lead_q   <= s1_lead_d;
            s1_nz_q     <= s1_nz_d;
        end
    end

    // Shift distance puts the leading one into the implicit hidden position.
    assign sh       = SH_W'(FRAC_W) - SH_W'(s1_lead_q);
    assign frac_shl = s1_frac_q << sh;
    assign exp_inc  = s1_exp_q + EXP_W'(1);
    assign exp_wide = CMP_W'(s1_exp_q);
    assign sh_wide  = CMP_W'(sh);

    always_comb begin
        res_sign = s1_sign_q;
        res_exp  = '0;
        res_frac = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_zero = 1'b0;
        if (s1_exp_q == EXP_MAX) begin
            res_exp  = s1_exp_q;
            res_frac = s1_frac_q;
        end else if (s1_carry_q) begin
            if (exp_inc == EXP_MAX) begin
                res_exp = EXP_MAX;
                res_ovf = 1'b1;
            end else begin
                res_exp  = exp_inc;
                res_frac = {s1_hidden_q, s1_frac_q[FRAC_W-1:1]};
            end
        end else if (s1_hidden_q) begin
            res_exp  = s1_exp_q;
            res_frac = s1_frac_q;
        end else if (s1_nz_q) begin
            // No denormal support: anything that would land at exponent 0 flushes.
            if (exp_wide > sh_wide) begin
                res_exp  = EXP_W'(exp_wide - sh_wide);
                res_frac = frac_shl;
            end else begin
                res_unf  = 1'b1;
                res_zero = 1'b1;
            end
        end else begin
            res_zero = 1'b1;
        end
    end

    always_comb begin
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_frac_d  = s2_frac_q;
        s2_ovf_d   = s2_ovf_q;
        s2_unf_d   = s2_unf_q;
        s2_zero_d  = s2_zero_q;
        if (s2_load) begin
            s2_sign_d = res_sign;
            s2_exp_d  = res_exp;
            s2_frac_d = res_frac;
            s2_ovf_d  = res_ovf;
            s2_unf_d  = res_unf;
            s2_zero_d = res_zero;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= s2_frac_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_unf_q   <= s2_unf_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = s2_sign_q;
    assign out_exp   = s2_exp_q;
    assign out_frac  = s2_frac_q;
    assign out_ovf   = s2_ovf_q;
    assign out_unf   = s2_unf_q;
    assign out_zero  = s2_zero_q;

endmodule
